// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared types and default constants for the multiply/divide
// sequencing controller.
//   state_t        - controller state encoding (3 bits)
//   MULT_ITERS_D   - default multiply iteration count (radix-4 Booth, 32b)
//   DIV_ITERS_D    - default divide iteration count (non-restoring, 32b)
//   CNT_W_D        - default iteration counter width
package multdiv_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam int MULT_ITERS_D = 16;
  localparam int DIV_ITERS_D  = 32;
  localparam int CNT_W_D      = 6;

endpackage

// File: rtl/multdiv_if.sv
// multdiv_if: handshake bundle between the processor/datapath and the
// multiply/divide controller.
//   master: drives start pulses and datapath flags, observes strobes/results
//   slave : the controller side
import multdiv_pkg::*;

interface multdiv_if #(
  parameter int CNT_W = CNT_W_D
);
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic             div_by_zero;
  logic             mult_ovf;
  logic             load;
  logic             step_en;
  logic             finish;
  logic             op_is_div;
  logic [CNT_W-1:0] iter;
  logic             busy;
  logic             data_resultRDY;
  logic             data_exception;

  modport master (
    output ctrl_MULT, ctrl_DIV, div_by_zero, mult_ovf,
    input  load, step_en, finish, op_is_div, iter, busy,
           data_resultRDY, data_exception
  );

  modport slave (
    input  ctrl_MULT, ctrl_DIV, div_by_zero, mult_ovf,
    output load, step_en, finish, op_is_div, iter, busy,
           data_resultRDY, data_exception
  );
endinterface

// File: rtl/multdiv_iter_cnt.sv
// multdiv_iter_cnt: CNT_W-bit iteration counter for the mult/div controller.
//   clk    - clock
//   clr_n  - synchronous active-low reset
//   i_clr  - synchronous clear strobe (controller LOAD state)
//   i_en   - count enable
//   o_cnt  - current count
// Terminal-count detection is done by the controller, not here.
import multdiv_pkg::*;

module multdiv_iter_cnt #(
  parameter int CNT_W = CNT_W_D
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_cnt
);
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!clr_n)     r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en)  r_cnt <= r_cnt + 1'b1;
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/multdiv_ctrl.sv
// multdiv_ctrl: sequencing controller for the iterative multiply/divide unit.
//   clk    - clock
//   clr_n  - synchronous active-low reset
//   bus    - multdiv_if.slave: start pulses, datapath flags, datapath
//            strobes (load/step_en/finish), op_is_div, iter, busy and the
//            result handshake (data_resultRDY/data_exception)
// Outputs are either registers or decodes of the state register; no input
// reaches an output combinationally.
import multdiv_pkg::*;

module multdiv_ctrl #(
  parameter int MULT_ITERS = MULT_ITERS_D,
  parameter int DIV_ITERS  = DIV_ITERS_D,
  parameter int CNT_W      = CNT_W_D
) (
  input  logic     clk,
  input  logic     clr_n,
  multdiv_if.slave bus
);
  localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_ITERS - 1);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_ITERS - 1);

  state_t           r_state;
  logic             r_op_div;
  logic             r_dz;
  logic             r_exc;
  logic [CNT_W-1:0] w_iter;
  logic             w_start;
  logic             w_last;
  logic             w_step;

  assign w_start = bus.ctrl_MULT | bus.ctrl_DIV;
  assign w_step  = (r_state == RUN);
  assign w_last  = (w_iter == (r_op_div ? DIV_LAST : MULT_LAST));

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      r_state  <= IDLE;
      r_op_div <= 1'b0;
      r_dz     <= 1'b0;
      r_exc    <= 1'b0;
    end else if (w_start) begin
      // Restart from any state; multiply wins a simultaneous start.
      r_state  <= LOAD;
      r_op_div <= bus.ctrl_DIV & ~bus.ctrl_MULT;
      r_dz     <= bus.div_by_zero & bus.ctrl_DIV & ~bus.ctrl_MULT;
      r_exc    <= 1'b0;
    end else begin
      case (r_state)
        LOAD: begin
          r_state <= r_dz ? DONE : RUN;
          if (r_dz) r_exc <= 1'b1;
        end
        RUN:     if (w_last) r_state <= FIX;
        FIX: begin
          r_state <= DONE;
          r_exc   <= r_op_div ? 1'b0 : bus.mult_ovf;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Counting stops on the last step so iter parks at N-1 instead of wrapping.
  multdiv_iter_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .clr_n (clr_n),
    .i_clr (r_state == LOAD),
    .i_en  (w_step & ~w_last),
    .o_cnt (w_iter)
  );

  assign bus.load           = (r_state == LOAD);
  assign bus.step_en        = w_step;
  assign bus.finish         = (r_state == FIX);
  assign bus.busy           = (r_state != IDLE);
  assign bus.data_resultRDY = (r_state == DONE);
  assign bus.op_is_div      = r_op_div;
  assign bus.data_exception = r_exc;
  assign bus.iter           = w_iter;
endmodule

// File: doc/multdiv_ctrl.md
Name: multdiv_ctrl

Overview:
Sequencing controller for the iterative multiply/divide unit.
- Accepts one-cycle start pulses, loads the operands and steps the shift/add datapath for a fixed number of iterations.
- Tracks the iterations on an internal 6-bit iteration counter and runs a single fix-up cycle at the end.
- Reports completion and any exception to the processor with one-cycle result handshakes.

Parameters:
MULT_ITERS, 16, iteration count for a multiply (radix-4 Booth); legal range 1..63
DIV_ITERS, 32, iteration count for a divide (non-restoring); legal range 1..63
CNT_W, 6, iteration counter width; must satisfy 2**CNT_W > max(MULT_ITERS, DIV_ITERS)

Ports:
clk  input  1  system clock; all state updates on the rising edge
clr_n  input  1  synchronous active-low reset; sampled on the rising edge of clk
ctrl_MULT  input  1  one-cycle multiply start pulse
ctrl_DIV  input  1  one-cycle divide start pulse
div_by_zero  input  1  datapath flag: divisor == 0; valid in the ctrl_DIV cycle
mult_ovf  input  1  datapath flag: product overflows 32 bits; valid in the FIX cycle
load  output  1  datapath operand and accumulator load strobe
step_en  output  1  datapath iteration enable
finish  output  1  fix-up strobe (divide remainder correction, multiply overflow check)
op_is_div  output  1  latched operation: 1 = divide, 0 = multiply
iter  output  CNT_W  current iteration index
busy  output  1  high in every state except IDLE
data_resultRDY  output  1  one-cycle result-valid pulse
data_exception  output  1  exception flag; valid in the data_resultRDY cycle

Behaviour:
- Reset: clr_n low at a rising edge forces the following.
  - State becomes IDLE.
  - iter, op_is_div and data_exception become 0.
  - All strobes become 0 (load, step_en, finish, busy, data_resultRDY).
  - This applies mid-operation too; the aborted operation produces no data_resultRDY.
  - clr_n has priority over start pulses.
- States: IDLE, LOAD, RUN, FIX, DONE. All outputs are registered or decoded purely from the state, with no input-to-output combinational paths.
- Start from any state: ctrl_MULT or ctrl_DIV high forces the following.
  - Next state is LOAD.
  - op_is_div latches ctrl_DIV & ~ctrl_MULT; a multiply wins when both pulses arrive together.
  - An internal dz_q register latches div_by_zero & ~ctrl_MULT & ctrl_DIV.
  - data_exception clears to 0.
  - A start that arrives while busy aborts the current operation. No data_resultRDY is issued for the aborted operation.
- LOAD: load = 1 for exactly one cycle and the iteration counter clears to 0.
  - If dz_q = 1, next state is DONE, with no RUN or FIX cycles.
  - Otherwise next state is RUN.
- RUN: step_en = 1 on every cycle and iter increments by 1 per cycle, starting at 0.
  - N is DIV_ITERS if op_is_div is 1, else MULT_ITERS.
  - When iter == N-1, next state is FIX. iter holds at N-1 and never wraps.
- FIX: finish = 1 for one cycle, then the next state is DONE.
  - A multiply registers data_exception <= mult_ovf in this cycle.
  - A divide registers data_exception <= 0 in this cycle.
- DONE: data_resultRDY = 1 for exactly one cycle, then the next state is IDLE.
  - On the divide-by-zero path, data_exception = 1 in this cycle.
  - data_exception holds its value until the next start or reset.
- Latency, counting the start pulse edge as cycle 0:
  - data_resultRDY is high in cycle N+3: 19 for a multiply and 35 for a divide with default parameters.
  - On the divide-by-zero path it is high in cycle 2.
- Exactly N step_en cycles occur per non-exception operation, and step_en never overlaps load or finish.
- busy is high from cycle 1 through the data_resultRDY cycle inclusive.
- Start pulses in IDLE with neither ctrl_MULT nor ctrl_DIV high leave the state unchanged.

Decomposition:
- Package multdiv_pkg holds:
  - the state enum (IDLE, LOAD, RUN, FIX, DONE, 3-bit encoding);
  - the default iteration constants MULT_ITERS_D = 16 and DIV_ITERS_D = 32;
  - CNT_W_D = 6.
- One sub-module, multdiv_iter_cnt. It is a CNT_W-bit synchronous up-counter with:
  - a synchronous active-low clear;
  - a synchronous clear strobe, asserted by the FSM in LOAD;
  - an enable, asserted by the FSM as step_en.
  Terminal-count comparison lives in the FSM, not in the counter.

Test Plan:
- Reset, then ctrl_MULT pulse at cycle 0 with mult_ovf = 0 -> expect:
  - load at cycle 1;
  - step_en in cycles 2..17 with iter 0..15;
  - finish at cycle 18;
  - data_resultRDY at cycle 19 with data_exception = 0;
  - busy low at cycle 20.
- ctrl_DIV pulse with div_by_zero = 0 -> expect:
  - 32 step_en cycles with iter ending at 31;
  - finish at cycle 34;
  - data_resultRDY at cycle 35 with data_exception = 0.
- ctrl_DIV pulse with div_by_zero = 1 -> expect:
  - load at cycle 1;
  - no step_en and no finish;
  - data_resultRDY and data_exception = 1 at cycle 2.
- ctrl_MULT with mult_ovf = 1 held during FIX -> expect data_exception = 1 in cycle 19. It remains 1 until the next ctrl_MULT, then clears in the cycle after that pulse.
- ctrl_DIV at cycle 0, then ctrl_MULT at cycle 10 -> expect:
  - no data_resultRDY near cycle 35;
  - a second load at cycle 11;
  - op_is_div = 0;
  - data_resultRDY at cycle 29.
  Also: simultaneous ctrl_MULT and ctrl_DIV gives op_is_div = 0 with the multiply timing.
- clr_n low for one cycle at cycle 8 of a multiply -> expect all outputs 0 from the next edge and no data_resultRDY. A subsequent ctrl_DIV completes normally in 35 cycles.
